// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with stall/flush/bubble control and load-use hazard detection.
// Define ID_EX_FWD_EN to add EX/MEM and WB operand forwarding (hazard output is then tied low).
`ifndef DSIZE
`define DSIZE 16
`endif

module id_ex_reg #(
   parameter int RSIZE = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [2:0]         id_op,
   input  logic [RSIZE-1:0]   id_rs1_addr,
   input  logic [RSIZE-1:0]   id_rs2_addr,
   input  logic [`DSIZE-1:0]  id_rs1_data,
   input  logic [`DSIZE-1:0]  id_rs2_data,
   input  logic [`DSIZE-1:0]  id_imm,
   input  logic               id_use_imm,
   input  logic               id_wr_en,
   input  logic [RSIZE-1:0]   id_wr_addr,
   input  logic               exm_wr_en,
   input  logic [RSIZE-1:0]   exm_wr_addr,
   input  logic [`DSIZE-1:0]  exm_data,
   input  logic               wb_wr_en,
   input  logic [RSIZE-1:0]   wb_wr_addr,
   input  logic [`DSIZE-1:0]  wb_data,
   output logic               ex_valid,
   output logic [2:0]         ex_op,
   output logic [`DSIZE-1:0]  ex_a,
   output logic [`DSIZE-1:0]  ex_b,
   output logic               ex_wr_en,
   output logic [RSIZE-1:0]   ex_wr_addr,
   output logic               hazard
);

   logic [`DSIZE-1:0] a_q;
   logic [`DSIZE-1:0] b_q;
   logic              load_bubble;

   // A detected hazard only turns into a bubble when decode is not already being held.
   assign load_bubble = flush || (hazard && !stall);

`ifdef ID_EX_FWD_EN
   logic [RSIZE-1:0] rs1_q;
   logic [RSIZE-1:0] rs2_q;
   logic             use_imm_q;
   logic             exm_hit_a;
   logic             exm_hit_b;
   logic             wb_hit_a;
   logic             wb_hit_b;

   always_comb begin
      exm_hit_a = exm_wr_en && (rs1_q != '0) && (exm_wr_addr == rs1_q);
      wb_hit_a  = wb_wr_en  && (rs1_q != '0) && (wb_wr_addr  == rs1_q);
      exm_hit_b = !use_imm_q && exm_wr_en && (rs2_q != '0) && (exm_wr_addr == rs2_q);
      wb_hit_b  = !use_imm_q && wb_wr_en  && (rs2_q != '0) && (wb_wr_addr  == rs2_q);
      ex_a = a_q;
      if (exm_hit_a)
         ex_a = exm_data;
      else if (wb_hit_a)
         ex_a = wb_data;
      ex_b = b_q;
      if (exm_hit_b)
         ex_b = exm_data;
      else if (wb_hit_b)
         ex_b = wb_data;
   end

   assign hazard = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_q     <= '0;
         rs2_q     <= '0;
         use_imm_q <= 1'b0;
      end else if (load_bubble) begin
         rs1_q     <= '0;
         rs2_q     <= '0;
         use_imm_q <= 1'b0;
      end else if (!stall) begin
         rs1_q     <= id_rs1_addr;
         rs2_q     <= id_rs2_addr;
         use_imm_q <= id_use_imm;
      end
   end
`else
   logic rs1_hit;
   logic rs2_hit;
   logic unused_fwd_inputs;

   assign ex_a = a_q;
   assign ex_b = b_q;

   // WB-distance producers are covered by register-file write-through, so only EX and EX/MEM matter.
   always_comb begin
      rs1_hit = (id_rs1_addr != '0) &&
                ((ex_valid && ex_wr_en && (ex_wr_addr == id_rs1_addr)) ||
                 (exm_wr_en && (exm_wr_addr == id_rs1_addr)));
      rs2_hit = !id_use_imm && (id_rs2_addr != '0) &&
                ((ex_valid && ex_wr_en && (ex_wr_addr == id_rs2_addr)) ||
                 (exm_wr_en && (exm_wr_addr == id_rs2_addr)));
      hazard  = id_valid && (rs1_hit || rs2_hit);
   end

   assign unused_fwd_inputs = ^{exm_data, wb_wr_en, wb_wr_addr, wb_data};
`endif

   // Operand b is resolved to imm or rs2 data at load, so ex_b never sees forwarding for imm ops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         ex_op      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         ex_wr_en   <= 1'b0;
         ex_wr_addr <= '0;
      end else if (load_bubble) begin
         ex_valid   <= 1'b0;
         ex_op      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         ex_wr_en   <= 1'b0;
         ex_wr_addr <= '0;
      end else if (stall) begin
         a_q        <= ex_a;
         b_q        <= ex_b;
      end else begin
         ex_valid   <= id_valid;
         ex_op      <= id_op;
         a_q        <= id_rs1_data;
         b_q        <= id_use_imm ? id_imm : id_rs2_data;
         ex_wr_en   <= id_valid && id_wr_en;
         ex_wr_addr <= id_wr_addr;
      end
   end

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: expected stage contents are queued as stimulus is driven
// and compared after the following clock edge; combinational outputs are checked directly.
`ifndef DSIZE
`define DSIZE 16
`endif

module tb_id_ex_reg;
   localparam int RSIZE = 4;
   localparam int DSIZE = `DSIZE;
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MUL = 3'd7;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             stall = 1'b0;
   logic             flush = 1'b0;
   logic             id_valid = 1'b0;
   logic [2:0]       id_op = '0;
   logic [RSIZE-1:0] id_rs1_addr = '0;
   logic [RSIZE-1:0] id_rs2_addr = '0;
   logic [DSIZE-1:0] id_rs1_data = '0;
   logic [DSIZE-1:0] id_rs2_data = '0;
   logic [DSIZE-1:0] id_imm = '0;
   logic             id_use_imm = 1'b0;
   logic             id_wr_en = 1'b0;
   logic [RSIZE-1:0] id_wr_addr = '0;
   logic             exm_wr_en = 1'b0;
   logic [RSIZE-1:0] exm_wr_addr = '0;
   logic [DSIZE-1:0] exm_data = '0;
   logic             wb_wr_en = 1'b0;
   logic [RSIZE-1:0] wb_wr_addr = '0;
   logic [DSIZE-1:0] wb_data = '0;
   logic             ex_valid;
   logic [2:0]       ex_op;
   logic [DSIZE-1:0] ex_a;
   logic [DSIZE-1:0] ex_b;
   logic             ex_wr_en;
   logic [RSIZE-1:0] ex_wr_addr;
   logic             hazard;

   id_ex_reg #(.RSIZE(RSIZE)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_op(id_op),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_use_imm(id_use_imm),
      .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
      .exm_wr_en(exm_wr_en), .exm_wr_addr(exm_wr_addr), .exm_data(exm_data),
      .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
      .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .hazard(hazard)
   );

   always #5 clk = ~clk;

   typedef struct {
      string            tag;
      logic             v;
      logic [2:0]       op;
      logic [DSIZE-1:0] a;
      logic [DSIZE-1:0] b;
      logic             we;
      logic [RSIZE-1:0] wa;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_ex(input string tag, input logic v, input logic [2:0] op,
                            input logic [DSIZE-1:0] a, input logic [DSIZE-1:0] b,
                            input logic we, input logic [RSIZE-1:0] wa);
      exp_t e;
      e.tag = tag; e.v = v; e.op = op; e.a = a; e.b = b; e.we = we; e.wa = wa;
      sb.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL sb_underflow: got no queued entry, expected one");
      end else begin
         e = sb.pop_front();
         chk({e.tag, ".valid"}, 64'(ex_valid), 64'(e.v));
         chk({e.tag, ".op"},    64'(ex_op),    64'(e.op));
         chk({e.tag, ".a"},     64'(ex_a),     64'(e.a));
         chk({e.tag, ".b"},     64'(ex_b),     64'(e.b));
         chk({e.tag, ".wr_en"}, 64'(ex_wr_en), 64'(e.we));
         chk({e.tag, ".wr_adr"},64'(ex_wr_addr),64'(e.wa));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      pop_check();
   endtask

   task automatic drive(input logic v, input logic [2:0] op,
                        input logic [RSIZE-1:0] r1, input logic [RSIZE-1:0] r2,
                        input logic [DSIZE-1:0] d1, input logic [DSIZE-1:0] d2,
                        input logic [DSIZE-1:0] imm, input logic ui,
                        input logic we, input logic [RSIZE-1:0] wa);
      id_valid = v; id_op = op; id_rs1_addr = r1; id_rs2_addr = r2;
      id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_use_imm = ui;
      id_wr_en = we; id_wr_addr = wa;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got no completion, expected finish before 50000");
      $fatal(1, "bench timeout");
   end

   initial begin
      // reset asserted from time 0
      #2;
      expect_ex("reset0", 0, 3'd0, '0, '0, 0, '0);
      pop_check();
      #1 rst_n = 1'b1;

      drive(1, OP_ADD, 4'd1, 4'd2, 16'd5, 16'd7, 16'd0, 0, 1, 4'd4);
      expect_ex("load_add", 1, OP_ADD, 16'd5, 16'd7, 1, 4'd4);
      tick();

      // asynchronous reset between edges
      #2 rst_n = 1'b0;
      expect_ex("async_rst", 0, 3'd0, '0, '0, 0, '0);
      #1 pop_check();
      rst_n = 1'b1;
      expect_ex("reload_add", 1, OP_ADD, 16'd5, 16'd7, 1, 4'd4);
      tick();

`ifdef ID_EX_FWD_EN
      stall = 1'b1;
      drive(1, OP_ADD, 4'd3, 4'd2, 16'h1, 16'h7, 16'h0, 0, 1, 4'd4);
      expect_ex("fwd_base", 1, OP_ADD, 16'd5, 16'd7, 1, 4'd4);
      tick();
      stall = 1'b0;
      expect_ex("fwd_load", 1, OP_ADD, 16'h1, 16'h7, 1, 4'd4);
      tick();
      exm_wr_en = 1; exm_wr_addr = 4'd3; exm_data = 16'h22;
      wb_wr_en = 1;  wb_wr_addr = 4'd3;  wb_data = 16'h11;
      #1 chk("fwd_exm_prio", 64'(ex_a), 64'h22);
      chk("fwd_haz_tied", 64'(hazard), 64'h0);
      exm_wr_en = 0;
      #1 chk("fwd_wb", 64'(ex_a), 64'h11);
      wb_wr_en = 0;
      #1 chk("fwd_none", 64'(ex_a), 64'h1);

      drive(1, OP_SUB, 4'd0, 4'd0, 16'h5, 16'h6, 16'h0, 0, 1, 4'd2);
      expect_ex("r0_load", 1, OP_SUB, 16'h5, 16'h6, 1, 4'd2);
      tick();
      exm_wr_en = 1; exm_wr_addr = 4'd0; exm_data = 16'hee;
      wb_wr_en = 1;  wb_wr_addr = 4'd0;  wb_data = 16'hdd;
      #1 chk("r0_a", 64'(ex_a), 64'h5);
      chk("r0_b", 64'(ex_b), 64'h6);
      exm_wr_en = 0; wb_wr_en = 0;

      drive(1, OP_MUL, 4'd1, 4'd2, 16'h3, 16'h0, 16'h0, 0, 1, 4'd7);
      expect_ex("mul_load", 1, OP_MUL, 16'h3, 16'h0, 1, 4'd7);
      tick();
      stall = 1'b1;
      wb_wr_en = 1; wb_wr_addr = 4'd2; wb_data = 16'h9;
      drive(1, OP_SUB, 4'd5, 4'd6, 16'h44, 16'h55, 16'h0, 0, 1, 4'd1);
      #1 chk("stall_fwd_b", 64'(ex_b), 64'h9);
      expect_ex("stall1", 1, OP_MUL, 16'h3, 16'h9, 1, 4'd7);
      tick();
      wb_wr_en = 0;
      expect_ex("stall2", 1, OP_MUL, 16'h3, 16'h9, 1, 4'd7);
      tick();
      expect_ex("stall3", 1, OP_MUL, 16'h3, 16'h9, 1, 4'd7);
      tick();
      stall = 1'b0;

      drive(1, OP_XOR, 4'd1, 4'd5, 16'h10, 16'h99, 16'h33, 1, 1, 4'd6);
      expect_ex("imm_load", 1, OP_XOR, 16'h10, 16'h33, 1, 4'd6);
      tick();
      exm_wr_en = 1; exm_wr_addr = 4'd5; exm_data = 16'h77;
      #1 chk("imm_no_fwd", 64'(ex_b), 64'h33);
      exm_wr_addr = 4'd1;
      #1 chk("imm_a_fwd", 64'(ex_a), 64'h77);
      exm_wr_en = 0;
`else
      drive(1, OP_SUB, 4'd4, 4'd2, 16'd8, 16'd8, 16'd0, 0, 1, 4'd5);
      #1 chk("haz_ex_rs1", 64'(hazard), 64'h1);
      expect_ex("haz_bubble", 0, 3'd0, '0, '0, 0, '0);
      tick();
      chk("haz_clear", 64'(hazard), 64'h0);
      expect_ex("after_haz", 1, OP_SUB, 16'd8, 16'd8, 1, 4'd5);
      tick();

      drive(1, OP_XOR, 4'd1, 4'd5, 16'h10, 16'hdead, 16'h33, 1, 1, 4'd6);
      #1 chk("haz_imm_off", 64'(hazard), 64'h0);
      expect_ex("imm_load", 1, OP_XOR, 16'h10, 16'h33, 1, 4'd6);
      tick();

      drive(1, OP_ADD, 4'd0, 4'd6, 16'h1, 16'h2, 16'h0, 0, 1, 4'd3);
      #1 chk("haz_ex_rs2", 64'(hazard), 64'h1);
      drive(1, OP_ADD, 4'd9, 4'd0, 16'h1, 16'h2, 16'h0, 0, 1, 4'd3);
      exm_wr_en = 1; exm_wr_addr = 4'd9;
      #1 chk("haz_exm", 64'(hazard), 64'h1);
      id_valid = 0;
      #1 chk("haz_novalid", 64'(hazard), 64'h0);
      id_valid = 1; id_rs1_addr = 4'd0; exm_wr_addr = 4'd0;
      #1 chk("haz_r0", 64'(hazard), 64'h0);
      exm_wr_en = 0;

      drive(1, OP_MUL, 4'd1, 4'd2, 16'h3, 16'h9, 16'h0, 0, 1, 4'd7);
      expect_ex("mul_load", 1, OP_MUL, 16'h3, 16'h9, 1, 4'd7);
      tick();
      stall = 1'b1;
      drive(1, OP_SUB, 4'd7, 4'd6, 16'h44, 16'h55, 16'h0, 0, 1, 4'd1);
      #1 chk("stall_haz", 64'(hazard), 64'h1);
      expect_ex("stall1", 1, OP_MUL, 16'h3, 16'h9, 1, 4'd7);
      tick();
      expect_ex("stall2", 1, OP_MUL, 16'h3, 16'h9, 1, 4'd7);
      tick();
      expect_ex("stall3", 1, OP_MUL, 16'h3, 16'h9, 1, 4'd7);
      tick();
      stall = 1'b0;
      drive(1, OP_ADD, 4'd1, 4'd2, 16'h3, 16'h9, 16'h0, 0, 1, 4'd7);
      expect_ex("post_stall", 1, OP_ADD, 16'h3, 16'h9, 1, 4'd7);
      tick();
`endif

      stall = 1'b1; flush = 1'b1;
      expect_ex("stall_flush", 0, 3'd0, '0, '0, 0, '0);
      tick();
      stall = 1'b0; flush = 1'b0;

      drive(1, OP_ADD, 4'd1, 4'd2, 16'h11, 16'h22, 16'h0, 0, 1, 4'd3);
      expect_ex("pre_flush", 1, OP_ADD, 16'h11, 16'h22, 1, 4'd3);
      tick();
      flush = 1'b1;
      expect_ex("flush", 0, 3'd0, '0, '0, 0, '0);
      tick();
      flush = 1'b0;

      drive(0, OP_XOR, 4'd1, 4'd2, 16'ha, 16'hb, 16'h0, 0, 1, 4'd8);
      expect_ex("invalid_load", 0, OP_XOR, 16'ha, 16'hb, 0, 4'd8);
      tick();

      // reset while stalled drops the held instruction
      drive(1, OP_SUB, 4'd1, 4'd2, 16'h44, 16'h55, 16'h0, 0, 1, 4'd2);
      expect_ex("rst_pre", 1, OP_SUB, 16'h44, 16'h55, 1, 4'd2);
      tick();
      stall = 1'b1;
      expect_ex("rst_hold", 1, OP_SUB, 16'h44, 16'h55, 1, 4'd2);
      tick();
      #2 rst_n = 1'b0;
      expect_ex("rst_stall", 0, 3'd0, '0, '0, 0, '0);
      #1 pop_check();
      rst_n = 1'b1;
      expect_ex("rst_post_stall", 0, 3'd0, '0, '0, 0, '0);
      tick();
      stall = 1'b0;
      expect_ex("rst_post_load", 1, OP_SUB, 16'h44, 16'h55, 1, 4'd2);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter RSIZE, default 4: register-address width.
REQ-002 SHALL size all data ports `DSIZE and op ports 3 bits, using the shared define file.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 stall  in  1  hold stage contents.
REQ-006 flush  in  1  replace stage contents with bubble.
REQ-007 id_valid  in  1  decode slot holds an instruction.
REQ-008 id_op  in  3  ALU operation code (ADD..MUL encodings).
REQ-009 id_rs1_addr, id_rs2_addr  in  RSIZE  source register numbers.
REQ-010 id_rs1_data, id_rs2_data  in  DSIZE  register-file read data.
REQ-011 id_imm  in  DSIZE  extended immediate; id_use_imm  in  1  selects imm as operand b.
REQ-012 id_wr_en  in  1, id_wr_addr  in  RSIZE  destination of instruction.
REQ-013 exm_wr_en  in  1, exm_wr_addr  in  RSIZE, exm_data  in  DSIZE  EX/MEM result.
REQ-014 wb_wr_en  in  1, wb_wr_addr  in  RSIZE, wb_data  in  DSIZE  writeback result.
REQ-015 ex_valid  out  1; ex_op  out  3; ex_a, ex_b  out  DSIZE  ALU operands.
REQ-016 ex_wr_en  out  1, ex_wr_addr  out  RSIZE  destination forwarded downstream.
REQ-017 hazard  out  1  decode must hold this cycle.

Function
REQ-018 Load: stall=0, flush=0, hazard=0 -> capture all id_* fields next edge; ex_valid=id_valid; latency 1 cycle.
REQ-019 Bubble: ex_valid=0, ex_wr_en=0, ex_op=0, data/address registers 0.
REQ-020 flush=1 SHALL load bubble regardless of stall (flush beats stall).
REQ-021 stall=1, flush=0 SHALL hold control fields; operand registers SHALL reload current ex_a/ex_b so forwarded values survive producer retirement.
REQ-022 ex_b SHALL equal registered immediate when registered use_imm=1, never forwarded.
REQ-023 Register 0 SHALL never match for forwarding or hazard; reads of r0 pass register data unchanged.
REQ-024 ex_wr_en SHALL be 0 whenever ex_valid=0.
REQ-025 All outputs except hazard (and ex_a/ex_b under FWD_EN) SHALL come directly from flops.

Reset
REQ-026 rst_n=0 SHALL immediately force bubble state (all outputs 0), independent of clk.
REQ-027 Reset mid-stall or mid-flush SHALL discard held instruction; first post-reset edge follows REQ-018..021.

Configuration
REQ-028 Macro ID_EX_FWD_EN defined: ex_a/ex_b source operands combinationally replaced by exm_data when exm_wr_en and address match, else wb_data on wb match, else registered data; EX/MEM priority over WB; hazard tied 0.
REQ-029 Macro ID_EX_FWD_EN undefined: ex_a/ex_b are registered data; hazard=1 when id_valid and a used source (rs1; rs2 only if !id_use_imm), nonzero, equals ex_wr_addr with ex_valid&ex_wr_en, or exm_wr_addr with exm_wr_en; hazard=1 with stall=0 SHALL load bubble; WB distance covered by register-file write-through.

Verification
REQ-030 Reset: rst_n low between edges -> ex_valid=0, ex_a=0, ex_b=0 same cycle.
REQ-031 Load ADD r1=5, r2=7, use_imm=0 -> next cycle ex_op=ADD, ex_a=5, ex_b=7, ex_valid=1.
REQ-032 FWD_EN: ex rs1=3, exm writes r3=0x22 and wb writes r3=0x11 -> ex_a=0x22; exm off -> 0x11; rs1=0 with matches -> register value.
REQ-033 stall 3 cycles while wb forwards r2=9 only in first cycle -> ex_b stays 9 throughout, ex_op unchanged.
REQ-034 stall=1 and flush=1 same edge -> ex_valid=0, ex_wr_en=0 next cycle.
REQ-035 No FWD_EN: ex holds valid write r4, id reads r4 -> hazard=1, next cycle bubble; use_imm=1 with rs2=r4 only -> hazard=0.
